// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES key schedule.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        KS128 = 2'd0,
        KS192 = 2'd1,
        KS256 = 2'd2
    } key_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DRAIN
    } state_t;

    // Key length in 32-bit words.
    function automatic logic [3:0] nk(input key_size_t ks);
        case (ks)
            KS128:   return 4'd4;
            KS192:   return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    // Number of rounds.
    function automatic logic [3:0] nr(input key_size_t ks);
        case (ks)
            KS128:   return 4'd10;
            KS192:   return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254, zero maps to zero) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int b = 7; b >= 0; b--) begin
            inv = gmul(inv, inv);
            if (b != 0) inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_expander_sub_word.sv
// SubWord: four parallel S-box lookups across a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    // Byte-wise substitution, purely combinational.
    always_comb begin
        out_word = {sbox(in_word[31:24]), sbox(in_word[23:16]),
                    sbox(in_word[15:8]),  sbox(in_word[7:0])};
    end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES key schedule: one schedule word per cycle, packed four at a
// time into 128-bit round keys on a valid/ready stream.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int OUT_SKID = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [1:0]   key_size,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         done
);

    localparam int DEPTH = (OUT_SKID != 0) ? 2 : 1;

    state_t       state_q, state_d;
    key_size_t    ks_q, ks_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [3:0]   ph_q, ph_d;
    logic [7:0]   rcon_q, rcon_d;
    word_t        win_q [8];
    word_t        win_d [8];
    word_t        asm_q [3];
    word_t        asm_d [3];
    logic [1:0]   ocnt_q, ocnt_d;
    logic [127:0] odata_q [2];
    logic [127:0] odata_d [2];
    logic [3:0]   oidx_q [2];
    logic [3:0]   oidx_d [2];
    logic         olast_q [2];
    logic         olast_d [2];

    logic [3:0]   nk_w;
    logic [5:0]   last_word;
    word_t        temp, w_back, sw_in, sw_out, gen_word, push_word;
    logic         pop, can_take, do_push, push_out;
    logic [1:0]   wslot;

    // Window depth 0 holds w[i-1]; depth Nk-1 holds w[i-Nk].
    assign nk_w      = nk(ks_q);
    assign last_word = {nr(ks_q), 2'b00} + 6'd3;
    assign temp      = win_q[0];
    assign w_back    = win_q[3'(nk_w - 4'd1)];
    assign sw_in     = (ph_q == 4'd0) ? {temp[23:0], temp[31:24]} : temp;

    sub_word u_sub_word (
        .in_word  (sw_in),
        .out_word (sw_out)
    );

    // Next schedule word; the three FIPS-197 cases keyed on i mod Nk.
    always_comb begin
        if (ph_q == 4'd0)
            gen_word = w_back ^ sw_out ^ {rcon_q, 24'h0};
        else if (nk_w == 4'd8 && ph_q == 4'd4)
            gen_word = w_back ^ sw_out;
        else
            gen_word = w_back ^ temp;
    end

    // During LOAD the key words rotate out of the top of the window.
    assign push_word = (state_q == ST_LOAD) ? win_q[7] : gen_word;
    assign pop       = (ocnt_q != 2'd0) && rk_ready;
    assign can_take  = (ocnt_q < 2'(DEPTH)) || pop;
    assign do_push   = ((state_q == ST_LOAD) || (state_q == ST_EXPAND)) &&
                       ((cnt_q[1:0] != 2'd3) || can_take);
    assign push_out  = do_push && (cnt_q[1:0] == 2'd3);

    // Control FSM, word counter, rcon, key window and 3-word assembly.
    always_comb begin
        state_d = state_q;
        ks_d    = ks_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        rcon_d  = rcon_q;
        win_d   = win_q;
        asm_d   = asm_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ks_d    = (key_size == 2'd3) ? KS256 : key_size_t'(key_size);
                    cnt_d   = 6'd0;
                    ph_d    = 4'd0;
                    rcon_d  = 8'h01;
                    for (int j = 0; j < 8; j++) win_d[7 - j] = key_in[255 - 32*j -: 32];
                end
            end
            ST_LOAD, ST_EXPAND: begin
                if (do_push) begin
                    win_d[0] = push_word;
                    for (int k = 1; k < 8; k++) win_d[k] = win_q[k - 1];
                    if (cnt_q[1:0] != 2'd3) asm_d[cnt_q[1:0]] = push_word;
                    cnt_d = cnt_q + 6'd1;
                    ph_d  = (ph_q == nk_w - 4'd1) ? 4'd0 : ph_q + 4'd1;
                    if (state_q == ST_EXPAND && ph_q == 4'd0) rcon_d = xtime(rcon_q);
                    if (state_q == ST_LOAD && cnt_q == {2'b00, nk_w - 4'd1})
                        state_d = ST_EXPAND;
                    if (state_q == ST_EXPAND && cnt_q == last_word)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && olast_q[0]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output buffer: head entry drives the stream, second entry absorbs a stall.
    always_comb begin
        ocnt_d  = ocnt_q - 2'(pop) + 2'(push_out);
        odata_d = odata_q;
        oidx_d  = oidx_q;
        olast_d = olast_q;
        wslot   = ocnt_q - 2'(pop);
        if (pop) begin
            odata_d[0] = odata_q[1];
            oidx_d[0]  = oidx_q[1];
            olast_d[0] = olast_q[1];
        end
        if (push_out) begin
            odata_d[wslot[0]] = {asm_q[0], asm_q[1], asm_q[2], push_word};
            oidx_d[wslot[0]]  = cnt_q[5:2];
            olast_d[wslot[0]] = (cnt_q == last_word);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            ks_q    <= KS128;
            cnt_q   <= 6'd0;
            ph_q    <= 4'd0;
            rcon_q  <= 8'h01;
            ocnt_q  <= 2'd0;
            for (int k = 0; k < 8; k++) win_q[k] <= '0;
            for (int k = 0; k < 3; k++) asm_q[k] <= '0;
            for (int k = 0; k < 2; k++) begin
                odata_q[k] <= '0;
                oidx_q[k]  <= '0;
                olast_q[k] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            ks_q    <= ks_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            rcon_q  <= rcon_d;
            ocnt_q  <= ocnt_d;
            win_q   <= win_d;
            asm_q   <= asm_d;
            odata_q <= odata_d;
            oidx_q  <= oidx_d;
            olast_q <= olast_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign rk_valid = (ocnt_q != 2'd0);
    assign rk_data  = odata_q[0];
    assign rk_index = oidx_q[0];
    assign rk_last  = olast_q[0];
    assign done     = pop && olast_q[0];

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key expansion vectors.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [1:0]   key_size;
    logic [255:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] got_data [16];
    logic [3:0]   got_idx  [16];
    logic         got_last [16];
    int n_keys, n_done, first_valid, done_cyc, stall_errs;

    localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    always #5 clk = ~clk;

    aes_key_expander #(.OUT_SKID(1)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .key_size (key_size),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_index (rk_index),
        .rk_last  (rk_last),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [1:0] ks, input logic [255:0] key);
        @(posedge clk); #1;
        key_size = ks;
        key_in   = key;
        start    = 1'b1;
    endtask

    // Iteration c samples the cycle after edge E(c); E0 is the start sample edge.
    task automatic run_job(input int max_cyc, input bit rnd, input bit poke);
        logic         stalled;
        logic [127:0] pd;
        logic [3:0]   pi;
        logic         pl;
        n_keys = 0; n_done = 0; first_valid = -1; done_cyc = -1; stall_errs = 0;
        stalled = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        for (int k = 0; k < 16; k++) begin
            got_data[k] = '0; got_idx[k] = '0; got_last[k] = 1'b0;
        end
        for (int c = 0; c < max_cyc && n_done == 0; c++) begin
            @(posedge clk); #1;
            start    = 1'b0;
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && (c == 9 || c == 10)) begin
                start    = 1'b1;
                key_in   = ~key_in;
                key_size = 2'd2;
            end
            @(negedge clk);
            if (stalled && !(rk_valid && rk_data == pd && rk_index == pi && rk_last == pl))
                stall_errs++;
            if (rk_valid && first_valid < 0) first_valid = c;
            if (rk_valid && rk_ready) begin
                if (n_keys < 16) begin
                    got_data[n_keys] = rk_data;
                    got_idx[n_keys]  = rk_index;
                    got_last[n_keys] = rk_last;
                end
                n_keys++;
            end
            if (done) begin
                n_done++;
                done_cyc = c;
                if (poke) start = 1'b1;
            end
            stalled = rk_valid && !rk_ready;
            pd = rk_data; pi = rk_index; pl = rk_last;
        end
        if (n_done == 0) check_eq("timeout_done", 0, 1);
        @(posedge clk); #1;
        start    = 1'b0;
        rk_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_job(input string tag, input int nr_exp, input logic [127:0] rk0,
                             input logic [127:0] rk1, input logic [127:0] rkl, input bit timed);
        int bad;
        check_eq({tag, "_count"}, n_keys, nr_exp + 1);
        check_eq({tag, "_rk0"}, got_data[0], rk0);
        check_eq({tag, "_rk1"}, got_data[1], rk1);
        check_eq({tag, "_rklast"}, got_data[nr_exp], rkl);
        bad = 0;
        for (int k = 0; k <= nr_exp; k++)
            if (got_idx[k] != 4'(k) || got_last[k] != (k == nr_exp)) bad++;
        check_eq({tag, "_seq"}, bad, 0);
        if (timed) begin
            check_eq({tag, "_first_valid"}, first_valid, 4);
            check_eq({tag, "_done_cycle"}, done_cyc, 4 * (nr_exp + 1));
        end
        check_eq({tag, "_idle"}, {busy, rk_valid}, 2'b00);
        check_eq({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; start = 1'b0; key_size = 2'd0; key_in = '0; rk_ready = 1'b1;
        #12;
        check_eq("reset_ctrl", {busy, rk_valid, rk_last, done}, 4'b0000);
        check_eq("reset_data", rk_data, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // AES-128, consumer always ready
        start_job(2'd0, K128);
        run_job(200, 1'b0, 1'b0);
        check_job("k128", 10, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                  128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                  128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b1);

        // AES-192
        start_job(2'd1, K192);
        run_job(200, 1'b0, 1'b0);
        check_job("k192", 12, 128'h8e73b0f7_da0e6452_c810f32b_809079e5,
                  128'h62f8ead2_522c6b7b_fe0c91f7_2402f5a5,
                  128'he98ba06f_448c773c_8ecc7204_01002202, 1'b1);

        // AES-256
        start_job(2'd2, K256);
        run_job(200, 1'b0, 1'b0);
        check_job("k256", 14, 128'h603deb10_15ca71be_2b73aef0_857d7781,
                  128'h1f352c07_3b6108d7_2d9810a3_0914dff4,
                  128'hfe4890d1_e6188d0b_046df344_706c631e, 1'b1);

        // AES-256 via reserved size code, random back-pressure
        start_job(2'd3, K256);
        run_job(600, 1'b1, 1'b0);
        check_job("k256_rnd", 14, 128'h603deb10_15ca71be_2b73aef0_857d7781,
                  128'h1f352c07_3b6108d7_2d9810a3_0914dff4,
                  128'hfe4890d1_e6188d0b_046df344_706c631e, 1'b0);
        check_eq("k256_rnd_rk2", got_data[2], 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
        check_eq("k256_rnd_stall_hold", stall_errs, 0);

        // start re-pulsed mid-job and on the done cycle
        start_job(2'd0, K128);
        run_job(200, 1'b0, 1'b1);
        check_job("k128_poke", 10, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                  128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                  128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b1);

        // restart after done
        start_job(2'd0, K128);
        run_job(200, 1'b0, 1'b0);
        check_job("k128_again", 10, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                  128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                  128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b1);

        // async reset in the middle of a 192 job
        start_job(2'd1, K192);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check_eq("pre_reset_valid", {busy, rk_valid}, 2'b11);
        n_rst = 1'b0;
        #1;
        check_eq("abort_ctrl", {busy, rk_valid, rk_last, done}, 4'b0000);
        check_eq("abort_data", rk_data, 128'h0);
        check_eq("abort_index", rk_index, 4'h0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        start_job(2'd0, K128);
        run_job(200, 1'b0, 1'b0);
        check_job("k128_post_rst", 10, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                  128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                  128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
